// File: rtl/i2c_pkg.sv
// Shared types and widths for the I2C target receiver.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_t;

  // Address byte selects us only for a write to our address.
  function automatic logic addr_hit(input logic [I2C_BYTE_W-1:0] b,
                                    input logic [I2C_ADDR_W-1:0] a);
    return (b[I2C_BYTE_W-1:1] == a) && !b[0];
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes scl/sda, keeps one history flop, and derives scl edges
// plus START/STOP bus conditions.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_h;
  logic                   sda_h;
  logic                   scl_s;

  // Flops reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_h    <= scl_sync[SYNC_STAGES-1];
      sda_h    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s && !scl_h;
  assign scl_fall  = !scl_s && scl_h;
  assign start_det = scl_s && sda_h && !sda_s;
  assign stop_det  = scl_s && !sda_h && sda_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: address match, byte shifter, ACK generation and
// a valid/ready holding register toward the fabric.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  addr_match,
  output logic                  busy,
  output logic                  overrun
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t                  state;
  logic [2:0]              bit_cnt;
  logic [I2C_BYTE_W-2:0]   shift;
  logic                    ack_phase;
  logic                    ack_en;
  logic [I2C_BYTE_W-1:0]   byte_next;
  logic                    byte_done;
  logic                    load;

  assign byte_next = {shift, sda_s};
  assign byte_done = scl_rise && (bit_cnt == 3'd7);

  always_comb begin
    load = 1'b0;
    if ((state == DATA) && byte_done && !start_det && !stop_det &&
        (!rx_valid || rx_ready))
      load = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      ack_phase  <= 1'b0;
      ack_en     <= 1'b0;
      sda_oe     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        rx_data  <= byte_next;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (start_det) begin
        state      <= ADDR;
        busy       <= 1'b1;
        bit_cnt    <= '0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        ack_phase  <= 1'b0;
      end else if (stop_det) begin
        state      <= IDLE;
        busy       <= 1'b0;
        bit_cnt    <= '0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        ack_phase  <= 1'b0;
      end else begin
        case (state)
          ADDR, DATA: begin
            if (scl_rise) begin
              shift   <= byte_next[I2C_BYTE_W-2:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_done) begin
                if (state == ADDR) begin
                  state <= addr_hit(byte_next, SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                end else begin
                  ack_en <= load;
                  if (!load) overrun <= 1'b1;
                  state <= DATA_ACK;
                end
              end
            end
          end
          // ack_phase splits the 9th bit: first fall opens the window,
          // second fall closes it; a NACK simply keeps sda_oe low.
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_phase <= 1'b1;
                sda_oe    <= (state == ADDR_ACK) || ack_en;
                if (state == ADDR_ACK) addr_match <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                state     <= DATA;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Scoreboard bench for i2c_slave_rx: a bus-level master, a transaction
// model predicting ACKs and delivered bytes, and a decoupled rx monitor.
module tb_i2c_slave_rx;

  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       rx_ready;
  logic       sda_in;
  logic       scl_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_match;
  logic       busy;
  logic       overrun;

  int   checks = 0;
  int   failures = 0;
  int   hs_count = 0;
  int   valid_cycles = 0;
  int   viol = 0;
  bit   ack_win = 1'b0;
  bit   model_full = 1'b0;
  bit   exp_overrun = 1'b0;
  logic [7:0] data_q[$];
  bit         ack_q[$];

  always #5 clk = ~clk;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_rx #(
    .SLAVE_ADDR  (7'h50),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .addr_match (addr_match),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receive monitor: every handshake must deliver the next predicted byte.
  always @(negedge clk) begin
    if (!rst && rx_valid) valid_cycles++;
    if (sda_oe && !ack_win) viol++;
    if (!rst && rx_valid && rx_ready) begin
      hs_count++;
      if (data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_data);
      end else begin
        check("rx_data", {24'h0, rx_data}, {24'h0, data_q.pop_front()});
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: only a write to 0x50 is ACKed; a byte is accepted when the
  // holding register is free (or drained continuously by rx_ready=1).
  task automatic model_txn(input logic [6:0] a, input bit rw, input int n,
                           input logic [7:0] d[4]);
    bit hit;
    hit = (a == 7'h50) && !rw;
    ack_q.push_back(hit);
    for (int i = 0; i < n; i++) begin
      if (!hit) begin
        ack_q.push_back(1'b0);
      end else if (!model_full || rx_ready) begin
        ack_q.push_back(1'b1);
        data_q.push_back(d[i]);
        model_full = !rx_ready;
      end else begin
        ack_q.push_back(1'b0);
        exp_overrun = 1'b1;
      end
    end
  endtask

  task automatic start_cond();
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(H);
  endtask

  task automatic rep_start();
    tick(2);
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(H);
  endtask

  task automatic stop_cond();
    tick(2);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic write_bit(input logic b);
    tick(2);
    sda_m = b; tick(H);
    scl_m = 1'b1; tick(H);
    scl_m = 1'b0;
  endtask

  task automatic ack_bit();
    bit exp;
    ack_win = 1'b1;
    sda_m = 1'b1;
    tick(2 + H);
    scl_m = 1'b1;
    tick(2);
    if (ack_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL ack_model_empty: got %0b expected queued ack", sda_oe);
    end else begin
      exp = ack_q.pop_front();
      check("ack_sda_oe", {31'h0, sda_oe}, {31'h0, exp});
    end
    tick(H - 2);
    scl_m = 1'b0;
    tick(5);
    ack_win = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    ack_bit();
  endtask

  task automatic do_txn(input logic [6:0] a, input bit rw, input int n,
                        input logic [7:0] d[4], input bit rep);
    model_txn(a, rw, n, d);
    if (rep) rep_start(); else start_cond();
    send_byte({a, rw});
    for (int i = 0; i < n; i++) send_byte(d[i]);
    stop_cond();
    tick(4);
  endtask

  initial begin
    logic [7:0] d[4];
    int         hs0;
    int         vc0;
    int         wait_n;
    logic [6:0] ra;
    bit         rrw;
    int         rn;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b1;
    tick(3);
    check("rst_sda_oe", {31'h0, sda_oe}, 32'h0);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_addr_match", {31'h0, addr_match}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    tick(3);

    // Addressed write of 0xA5 with the consumer always ready.
    d = '{8'hA5, 8'h00, 8'h00, 8'h00};
    hs0 = hs_count; vc0 = valid_cycles;
    model_txn(7'h50, 1'b0, 1, d);
    start_cond();
    tick(3);
    check("t1_busy_start", {31'h0, busy}, 32'h1);
    send_byte(8'hA0);
    check("t1_addr_match", {31'h0, addr_match}, 32'h1);
    send_byte(8'hA5);
    stop_cond();
    tick(4);
    check("t1_busy_stop", {31'h0, busy}, 32'h0);
    check("t1_addr_match_stop", {31'h0, addr_match}, 32'h0);
    check("t1_overrun", {31'h0, overrun}, 32'h0);
    check("t1_valid_cycles", valid_cycles - vc0, 32'd1);
    check("t1_handshakes", hs_count - hs0, 32'd1);

    // Wrong address: nothing ACKed, nothing delivered.
    d = '{8'h3C, 8'h00, 8'h00, 8'h00};
    hs0 = hs_count;
    model_txn(7'h51, 1'b0, 1, d);
    start_cond();
    send_byte(8'hA2);
    check("t2_addr_match", {31'h0, addr_match}, 32'h0);
    send_byte(8'h3C);
    stop_cond();
    tick(4);
    check("t2_handshakes", hs_count - hs0, 32'd0);

    // Read request to our address is ignored until STOP.
    hs0 = hs_count;
    do_txn(7'h50, 1'b1, 1, d, 1'b0);
    check("t3_busy", {31'h0, busy}, 32'h0);
    check("t3_handshakes", hs_count - hs0, 32'd0);

    // Consumer stalled: second byte is NACKed and flags overrun.
    rx_ready = 1'b0;
    d = '{8'h11, 8'h22, 8'h00, 8'h00};
    do_txn(7'h50, 1'b0, 2, d, 1'b0);
    check("t4_rx_valid", {31'h0, rx_valid}, 32'h1);
    check("t4_rx_data", {24'h0, rx_data}, 32'h11);
    check("t4_overrun", {31'h0, overrun}, {31'h0, exp_overrun});
    rx_ready = 1'b1;
    tick(3);
    model_full = 1'b0;
    check("t4_drained", data_q.size(), 32'd0);

    // Repeated START mid-byte discards the partial byte.
    hs0 = hs_count;
    ack_q.push_back(1'b1);
    start_cond();
    send_byte(8'hA0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    d = '{8'h7E, 8'h00, 8'h00, 8'h00};
    do_txn(7'h50, 1'b0, 1, d, 1'b1);
    check("t5_rx_data", {24'h0, rx_data}, 32'h7E);
    check("t5_handshakes", hs_count - hs0, 32'd1);

    // Reset while the data ACK is being driven.
    rx_ready = 1'b0;
    ack_q.push_back(1'b1);
    start_cond();
    send_byte(8'hA0);
    for (int i = 7; i >= 0; i--) write_bit(i[0]);
    ack_win = 1'b1;
    sda_m = 1'b1;
    wait_n = 0;
    while (!sda_oe && wait_n < 40) begin
      tick(1);
      wait_n++;
    end
    check("t6_oe_before_rst", {31'h0, sda_oe}, 32'h1);
    rst = 1'b1;
    tick(1);
    check("t6_sda_oe", {31'h0, sda_oe}, 32'h0);
    check("t6_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("t6_busy", {31'h0, busy}, 32'h0);
    check("t6_overrun", {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    model_full = 1'b0;
    exp_overrun = 1'b0;
    tick(2);
    ack_win = 1'b0;
    rx_ready = 1'b1;
    stop_cond();
    tick(4);
    d = '{8'hC3, 8'h00, 8'h00, 8'h00};
    do_txn(7'h50, 1'b0, 1, d, 1'b0);
    check("t6_fresh_rx_data", {24'h0, rx_data}, 32'hC3);

    // Randomized transactions against the model.
    for (int t = 0; t < 20; t++) begin
      ra  = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
      rrw = ($urandom_range(0, 3) == 0);
      rn  = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      do_txn(ra, rrw, rn, d, 1'b0);
    end

    check("end_data_q_empty", data_q.size(), 32'd0);
    check("end_ack_q_empty", ack_q.size(), 32'd0);
    check("end_oe_outside_window", viol, 32'd0);
    check("end_overrun", {31'h0, overrun}, 32'h0);
    check("end_busy", {31'h0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- Write-only I2C target (slave) receiver; the downstream consumer of the master FSM's scl/sda lines and the source of its ack_in.
- Oversamples scl/sda on the system clock and detects START, STOP and repeated START.
- Shifts in a 7-bit address plus R/W bit, then data bytes. ACKs each byte by driving SDA low, and hands received bytes to the fabric through a valid/ready holding register.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit target address this block responds to.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (legal range 2–3).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- scl_in  input  1  I2C clock line as seen at pad (asynchronous).
- sda_in  input  1  I2C data line as seen at pad (asynchronous).
- sda_oe  output  1  1 = pull SDA low (ACK). Open-drain enable; never drives high.
- rx_data  output  8  received data byte, MSB first on the wire.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- addr_match  output  1  high from address-ACK until STOP or repeated START.
- busy  output  1  high between a detected START and the following STOP.
- overrun  output  1  sticky; byte arrived while holding register full. Cleared by rst only.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE. sda_oe=0, rx_valid=0, rx_data=8'h00, addr_match=0, busy=0, overrun=0, shift reg and bit count cleared. Synchronizer flops reset to 1 (bus idle). Reset mid-transfer releases SDA the next cycle.
- Inputs pass through SYNC_STAGES flops, then one history flop. Edges (scl_rise, scl_fall, sda_rise, sda_fall) are derived from synchronized vs history values.
- Bus timing requirement: each scl high/low phase lasts at least 4 clk cycles.
- START: sda_fall while synced scl=1. Sets busy=1, clears bit count, enters ADDR from any state, including mid-byte (partial byte discarded).
- STOP: sda_rise while scl=1. Returns to IDLE from any state; clears busy and addr_match; releases sda_oe.
- START/STOP take priority over a same-cycle scl edge.
- Data bits are sampled on scl_rise, MSB first. A 3-bit counter wraps after bit 8.
- States:
  - IDLE → ADDR on START.
  - ADDR: after 8 bits, compare bits[7:1] with SLAVE_ADDR and require bits[0]=0 (write).
    - Match → ADDR_ACK.
    - Mismatch, or R/W=1 → IGNORE (no ACK; SDA stays released).
  - ADDR_ACK: assert sda_oe on the scl_fall after bit 8; set addr_match. Release on the next scl_fall, then → DATA.
  - DATA: after 8 bits, decide the ACK.
    - Holding register empty, or being emptied this cycle (rx_ready=1): load rx_data; rx_valid=1 in the cycle following the 8th scl_rise; → DATA_ACK with ACK.
    - Otherwise: byte dropped, overrun=1, → DATA_ACK with NACK (sda_oe stays 0).
  - DATA_ACK: when ACKing, sda_oe=1 from the next scl_fall to the following scl_fall; then → DATA.
  - IGNORE: wait for START or STOP.
- rx_valid clears in the cycle after rx_valid&&rx_ready. A simultaneous load and consume yields rx_valid=1 with the new byte.
- sda_oe is only ever high during ADDR_ACK or DATA_ACK windows.

Decomposition:
- Package i2c_pkg: state enum (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE), I2C_ADDR_W=7, I2C_BYTE_W=8.
- One sub-module, i2c_line_sync: synchronizer, history flop and edge/START/STOP detect for both lines.
- FSM, shifter and holding register live in i2c_slave_rx.

Test Plan:
- Write 0xA0 (addr 0x50, W), then 0xA5, STOP, rx_ready=1 → sda_oe pulses in both 9th-bit windows; rx_valid for exactly 1 cycle with rx_data=8'hA5; busy 1→0 at STOP; overrun=0.
- Address 0x51 (write) followed by byte 0x3C → sda_oe never asserts; addr_match=0; rx_valid=0.
- Address 0x50 with R/W=1 → NACK (sda_oe=0); IGNORE until STOP; busy=0 afterwards.
- rx_ready=0; write bytes 0x11, 0x22 → first ACKed with rx_data=8'h11 held and rx_valid=1; second NACKed, overrun=1, rx_data still 8'h11.
- Repeated START after 4 data bits, then addr 0x50 W + byte 0x7E → partial byte discarded, rx_data=8'h7E, single rx_valid.
- rst asserted while sda_oe=1 during data ACK → next cycle sda_oe=0, rx_valid=0, busy=0; a fresh transaction then completes normally.
